// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_arbiter
// Brief    : Round-robin selection of one ready reservation-station slot per
//            cycle into a single registered ALU issue stage.
//            Optional macro ALU_ISSUE_PERF_EN adds issue/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pause,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_v1,
    input  logic [32*NREQ-1:0]   req_v2,
    input  logic [3*NREQ-1:0]    req_des,
    input  logic [NREQ-1:0]      req_branch,
    output logic [NREQ-1:0]      grant,
    output logic                 alu_valid,
    output logic [4:0]           alu_op,
    output logic [31:0]          alu_v1,
    output logic [31:0]          alu_v2,
    output logic [2:0]           alu_des,
`ifdef ALU_ISSUE_PERF_EN
    output logic [15:0]          issue_cnt,
    output logic [15:0]          stall_cnt,
`endif
    output logic                 alu_branch
);

    localparam logic [4:0] C_NOP_OP = 5'b11111;

    logic              accept;
    logic [NREQ-1:0]   grant_d;
    logic              hit;
    logic [PTRW-1:0]   gidx;
    int                scan_idx;

    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic              alu_valid_q;
    logic [4:0]        alu_op_q;
    logic [31:0]       alu_v1_q;
    logic [31:0]       alu_v2_q;
    logic [2:0]        alu_des_q;
    logic              alu_branch_q;

    logic [4:0]        sel_op;
    logic [31:0]       sel_v1;
    logic [31:0]       sel_v2;
    logic [2:0]        sel_des;
    logic              sel_branch;

    assign accept = rst & ~pause & ~flush;

    // Scan upward from ptr with wrap-around; the first valid slot wins.
    always_comb begin
        grant_d  = '0;
        hit      = 1'b0;
        gidx     = '0;
        scan_idx = 0;
        if (accept) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = int'(ptr_q) + k;
                if (scan_idx >= NREQ) begin
                    scan_idx = scan_idx - NREQ;
                end
                if (!hit && req_valid[scan_idx]) begin
                    hit               = 1'b1;
                    gidx              = PTRW'(scan_idx);
                    grant_d[scan_idx] = 1'b1;
                end
            end
        end
    end

    assign grant = grant_d;

    always_comb begin
        sel_op     = req_op [5*int'(gidx)  +: 5];
        sel_v1     = req_v1 [32*int'(gidx) +: 32];
        sel_v2     = req_v2 [32*int'(gidx) +: 32];
        sel_des    = req_des[3*int'(gidx)  +: 3];
        sel_branch = req_branch[gidx];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hit) begin
            ptr_d = (gidx == PTRW'(NREQ-1)) ? '0 : gidx + 1'b1;
        end
    end

    // Reset beats flush beats pause; an accepted cycle without a grant issues a NOP.
    always_ff @(posedge clk) begin
        if (!rst || flush || (!pause && !hit)) begin
            alu_valid_q  <= 1'b0;
            alu_op_q     <= C_NOP_OP;
            alu_v1_q     <= '0;
            alu_v2_q     <= '0;
            alu_des_q    <= '0;
            alu_branch_q <= 1'b0;
        end else if (!pause) begin
            alu_valid_q  <= 1'b1;
            alu_op_q     <= sel_op;
            alu_v1_q     <= sel_v1;
            alu_v2_q     <= sel_v2;
            alu_des_q    <= sel_des;
            alu_branch_q <= sel_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign alu_valid  = alu_valid_q;
    assign alu_op     = alu_op_q;
    assign alu_v1     = alu_v1_q;
    assign alu_v2     = alu_v2_q;
    assign alu_des    = alu_des_q;
    assign alu_branch = alu_branch_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (hit) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (pause && |req_valid) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_arbiter
// Brief    : Directed self-checking bench for alu_issue_arbiter (NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_arbiter;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                pause;
    logic                flush;
    logic [NREQ-1:0]     req_valid;
    logic [5*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_v1;
    logic [32*NREQ-1:0]  req_v2;
    logic [3*NREQ-1:0]   req_des;
    logic [NREQ-1:0]     req_branch;
    logic [NREQ-1:0]     grant;
    logic                alu_valid;
    logic [4:0]          alu_op;
    logic [31:0]         alu_v1;
    logic [31:0]         alu_v2;
    logic [2:0]          alu_des;
    logic                alu_branch;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0]         issue_cnt;
    logic [15:0]         stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NREQ(NREQ), .PTRW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_v1     (req_v1),
        .req_v2     (req_v2),
        .req_des    (req_des),
        .req_branch (req_branch),
        .grant      (grant),
        .alu_valid  (alu_valid),
        .alu_op     (alu_op),
        .alu_v1     (alu_v1),
        .alu_v2     (alu_v2),
        .alu_des    (alu_des),
`ifdef ALU_ISSUE_PERF_EN
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .alu_branch (alu_branch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks happen 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_nop(input string tag);
        check({tag, "_valid"}, 32'(alu_valid), 32'd0);
        check({tag, "_op"},    32'(alu_op),    32'h1F);
        check({tag, "_des"},   32'(alu_des),   32'd0);
        check({tag, "_v1"},    alu_v1,         32'd0);
        check({tag, "_br"},    32'(alu_branch), 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        pause = 1'b0;
        flush = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_op [5*i  +: 5]  = 5'(i + 1);
            req_v1 [32*i +: 32] = 32'(100 + i);
            req_v2 [32*i +: 32] = 32'(200 + i);
            req_des[3*i  +: 3]  = 3'(i + 1);
            req_branch[i]       = i[0];
        end

        // Reset state
        tick(); tick();
        check("rst_grant", 32'(grant), 32'd0);
        check_nop("rst");

        // Round-robin over four valid slots
        rst = 1'b1;
        settle();
        check("rr_g0", 32'(grant), 32'b0001);
        tick();
        check("rr_des0", 32'(alu_des), 32'd1);
        check("rr_op0", 32'(alu_op), 32'd1);
        check("rr_val0", 32'(alu_valid), 32'd1);
        settle();
        check("rr_g1", 32'(grant), 32'b0010);
        tick();
        check("rr_des1", 32'(alu_des), 32'd2);
        check("rr_v2_1", alu_v2, 32'd201);
        check("rr_br1", 32'(alu_branch), 32'd1);
        settle();
        check("rr_g2", 32'(grant), 32'b0100);
        tick();
        check("rr_des2", 32'(alu_des), 32'd3);
        settle();
        check("rr_g3", 32'(grant), 32'b1000);
        tick();
        check("rr_des3", 32'(alu_des), 32'd4);
        check("rr_v1_3", alu_v1, 32'd103);

        // ptr is 0; issue slot 2 alone to move ptr to 3
        req_valid = 4'b0100;
        settle();
        check("mv_g", 32'(grant), 32'b0100);
        tick();
        // Wrap-around from ptr=3 with slots 1 and 3 valid
        req_valid = 4'b1010;
        settle();
        check("wrap_g3", 32'(grant), 32'b1000);
        tick();
        check("wrap_des3", 32'(alu_des), 32'd4);
        req_valid = 4'b0010;
        settle();
        check("wrap_g1", 32'(grant), 32'b0010);
        tick();
        check("wrap_des1", 32'(alu_des), 32'd2);

        // ptr is 2; slot 2 issues ADD 5+7 -> des 4, then pause for 3 cycles
        req_op [10 +: 5]  = 5'b00000;
        req_v1 [64 +: 32] = 32'd5;
        req_v2 [64 +: 32] = 32'd7;
        req_des[6  +: 3]  = 3'd4;
        req_valid = 4'b0100;
        settle();
        check("add_g", 32'(grant), 32'b0100);
        tick();
        req_valid = 4'b1011;
        pause = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("pause_g", 32'(grant), 32'd0);
            tick();
            check("pause_op", 32'(alu_op), 32'd0);
            check("pause_v1", alu_v1, 32'd5);
            check("pause_v2", alu_v2, 32'd7);
            check("pause_des", 32'(alu_des), 32'd4);
            check("pause_val", 32'(alu_valid), 32'd1);
        end

        // pause and flush together: flush wins, NOP loaded
        flush = 1'b1;
        settle();
        check("flush_g", 32'(grant), 32'd0);
        tick();
        check_nop("flush");

        // Idle accepted cycle loads NOP; ptr still 3
        pause = 1'b0;
        flush = 1'b0;
        req_valid = 4'b0000;
        settle();
        check("idle_g", 32'(grant), 32'd0);
        tick();
        check_nop("idle");

        // Mid-stream reset
        req_valid = 4'b1111;
        settle();
        check("ms_g3", 32'(grant), 32'b1000);
        tick();
        settle();
        check("ms_g0", 32'(grant), 32'b0001);
        tick();
        check("ms_valid", 32'(alu_valid), 32'd1);
        rst = 1'b0;
        settle();
        check("msrst_g", 32'(grant), 32'd0);
        tick();
        check_nop("msrst");
        rst = 1'b1;
        settle();
        check("post_rst_g", 32'(grant), 32'b0001);
        tick();
        check("post_rst_des", 32'(alu_des), 32'd1);

`ifdef ALU_ISSUE_PERF_EN
        rst = 1'b0;
        tick();
        check("cnt_rst_issue", 32'(issue_cnt), 32'd0);
        check("cnt_rst_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) tick();
        pause = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check("cnt_issue10", 32'(issue_cnt), 32'd10);
        check("cnt_stall3", 32'(stall_cnt), 32'd3);
        pause = 1'b0;
        for (int c = 0; c < 65535 - 10; c++) tick();
        check("cnt_issue_max", 32'(issue_cnt), 32'hFFFF);
        tick();
        check("cnt_issue_wrap", 32'(issue_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesting reservation-station slots (2..8).
REQ-002 Parameter PTRW, default 2, round-robin pointer width, equal to clog2(NREQ).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 pause  input  1  ALU stall; output stage holds when high.
REQ-006 flush  input  1  branch-mispredict flush; discards the pending issue.
REQ-007 req_valid  input  NREQ  slot i has operands ready.
REQ-008 req_op  input  5*NREQ  ALU opcode of slot i, bits [5i+4:5i].
REQ-009 req_v1 / req_v2  input  32*NREQ each  operand values of slot i.
REQ-010 req_des  input  3*NREQ  ROB tag of slot i; 0 is reserved for "no destination".
REQ-011 req_branch  input  NREQ  slot i is a branch compare.
REQ-012 grant  output  NREQ  one-hot, combinational; the slot is consumed at this edge.
REQ-013 alu_valid  output  1  registered; the issue register holds a real operation.
REQ-014 alu_op / alu_v1 / alu_v2 / alu_des / alu_branch  output  5/32/32/3/1  registered operation presented to the ALU.

Function
REQ-015 accept = rst & ~pause & ~flush.
REQ-016 When accept is high, grant selects the first asserted req_valid bit at or after ptr, scanning upward with wrap-around modulo NREQ.
REQ-017 When accept is low or no req_valid bit is set, grant is all zero.
REQ-018 grant has at most one bit set and never asserts for a slot whose req_valid is low.
REQ-019 On an edge with accept high and grant[i] set, the issue register loads slot i fields, alu_valid becomes 1, and ptr becomes (i+1) mod NREQ.
REQ-020 On an edge with accept high and no grant, the issue register loads the NOP: alu_valid 0, alu_op 5'b11111, alu_des 0, alu_v1/alu_v2 0, alu_branch 0; ptr is unchanged.
REQ-021 Latency: a request granted in cycle N appears on the alu_* outputs after the rising edge ending cycle N, one cycle, with no bypass path.
REQ-022 While pause is high and flush is low, the issue register and ptr hold; throughput is at most one issue per unpaused cycle.
REQ-023 An edge with flush high loads the NOP into the issue register regardless of pause, with ptr unchanged; flush has priority over pause.
REQ-024 Requesters deassert req_valid for a granted slot before the next edge; the arbiter does not track per-slot state.
REQ-025 When NREQ is not a power of two, ptr wraps from NREQ-1 to 0.

Reset
REQ-026 An edge with rst low loads the NOP into the issue register and clears ptr to 0; rst has priority over flush and pause.
REQ-027 While rst is low, grant is all zero.
REQ-028 The first grant after reset goes to the lowest-indexed valid slot.

Configuration
REQ-029 Macro ALU_ISSUE_PERF_EN compiles in the performance counters.
REQ-030 With ALU_ISSUE_PERF_EN defined, the block adds output issue_cnt [15:0], which increments on each edge loading alu_valid=1.
REQ-031 With ALU_ISSUE_PERF_EN defined, the block adds output stall_cnt [15:0], which increments on each edge with rst high, pause high and any req_valid set.
REQ-032 Both counters wrap at 16'hFFFF to 0 and clear on reset.
REQ-033 Without ALU_ISSUE_PERF_EN, the counter ports and counter logic are absent and all other behaviour is identical.

Verification
REQ-034 Reset then all four slots valid for 4 unpaused cycles -> grants 0001, 0010, 0100, 1000; alu_des matches slot tags one cycle after each grant.
REQ-035 ptr=3 with only slots 1 and 3 valid -> grant 1000, then next cycle grant 0010 (wrap-around).
REQ-036 Slot 2 issues ADD 5+7 with des=4, then pause held 3 cycles -> alu_op 00000, alu_v1 5, alu_v2 7 and alu_des 4 stable all 3 cycles; grant 0 during pause.
REQ-037 pause and flush both high with the issue register valid -> next edge alu_valid 0, alu_op 11111, alu_des 0; grant 0.
REQ-038 rst low mid-stream with slots valid -> next edge NOP outputs and ptr 0; after release, slot 0 granted first.
REQ-039 With ALU_ISSUE_PERF_EN: 10 issues plus 3 paused cycles with slots pending -> issue_cnt 10, stall_cnt 3; preload issue_cnt 16'hFFFF plus one issue -> 0.
